eth_axi_lite_slave_regs: RTL and testbench
==========================================

Name: eth_axi_lite_slave_regs

Overview:
AXI4-Lite slave (responder) register bank behind the eth_axi IP's S00_AXI port, the target of master-VIP write/read bursts.
- Provides 4 x 32-bit read/write registers at offsets 0x0, 0x4, 0x8, 0xC.
- Exports register contents plus per-register write pulses to the Ethernet user logic.
- Independent write and read channel FSMs, full byte-strobe support, always-OKAY responses.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response, always 2'b00.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- reg_out  out  4x32  current register values (reg_out[i] = register i).
- reg_wr_pulse  out  4  one-cycle pulse when register i is written.

Behaviour:
- Reset (S_AXI_ARESET=1 at a clock edge):
  - All registers, AWREADY, WREADY, ARREADY, BVALID, RVALID, RDATA and reg_wr_pulse go to 0.
  - Readies rise the first cycle after reset deasserts.
  - Reset mid-transaction aborts it; no write is committed and no response is issued.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AWREADY=1 only in W_IDLE or W_HAVE_W; WREADY=1 only in W_IDLE or W_HAVE_AW. Both are registered.
  - W_IDLE with AW and W handshaking in the same cycle: commit the write, go to W_RESP.
  - W_IDLE with only AW: latch the address, go to W_HAVE_AW. With only W: latch data and strobe, go to W_HAVE_W.
  - W_HAVE_AW or W_HAVE_W: on the missing handshake, commit the write and go to W_RESP.
  - Commit:
    - For each byte b with WSTRB[b]=1, reg[addr[3:2]][8b+7:8b] takes WDATA[8b+7:8b] on the commit edge.
    - reg_wr_pulse[addr[3:2]] is high the following cycle, even when WSTRB=0.
    - BVALID=1 the cycle after commit.
  - W_RESP: hold BVALID until BREADY, then return to W_IDLE. No new AW/W is accepted while BVALID=1.
  - Minimum write turnaround: handshake cycle, then BVALID the next cycle.
- Read FSM states: R_IDLE, R_RESP.
  - ARREADY=1 in R_IDLE only.
  - On AR handshake: RDATA captures reg[ARADDR[3:2]] and RVALID=1 the next cycle (latency 1).
  - R_RESP: RDATA and RVALID are held stable until RREADY, then return to R_IDLE.
- Simultaneous read and write to the same register in the same cycle: the read returns the pre-write value.
- Channels are fully independent; no ordering between reads and writes is guaranteed beyond the above.
- No address is out of range at width 4, so SLVERR/DECERR never occur.

Decomposition:
- Package eth_axi_regs_pkg holds:
  - register offsets REG_CTRL=0x0, REG_1=0x4, REG_2=0x8, REG_3=0xC;
  - NUM_REGS=4;
  - RESP_OKAY=2'b00;
  - typedef write_state_t and typedef read_state_t.
- Single module; no sub-module. The byte-strobe merge is a small function in the package.

Test Plan:
- Reset held 20 cycles, then released -> all readies 0 during reset, 1 one cycle after; reg_out all 0; reading 0x0..0xC returns 0x0 with RRESP=0.
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back -> RDATA 0x1, 0x2, 0x3, 0x4, BRESP=RRESP=0; reg_wr_pulse fires once per register.
- Write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 over a prior value of 0x2 -> read returns 0x00BB00DD.
- W presented 3 cycles before AW, then the reverse order -> both commit correctly; BVALID appears exactly 1 cycle after the second handshake.
- BREADY held low 10 cycles -> BVALID stays high; AWREADY and WREADY stay 0; a second write is accepted only after the B handshake. Likewise RREADY low -> RDATA held stable.
- Reset asserted the cycle after an AW handshake, before W -> no write is committed; BVALID=0; the register reads 0 after reset.

Source files
------------

// File: rtl/eth_axi_regs_pkg.sv
// eth_axi_regs_pkg
// Shared definitions for the eth_axi S00_AXI register bank: register offsets,
// bank geometry, response codes, channel FSM state types and the byte-strobe
// merge helper used when a write is committed.
package eth_axi_regs_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);

  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_1    = 4'h4;
  localparam logic [3:0] REG_2    = 4'h8;
  localparam logic [3:0] REG_3    = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } write_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } read_state_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/eth_axi_lite_slave_regs.sv
// eth_axi_lite_slave_regs
// AXI4-Lite responder holding four 32-bit read/write registers (offsets
// 0x0/0x4/0x8/0xC) for the Ethernet user logic.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET      clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* write address, data and response channels
//   S_AXI_AR* / S_AXI_R*           read address and data channels
//   reg_out                        current register contents (reg_out[i] = reg i)
//   reg_wr_pulse                   one-cycle pulse per register on each write
// Write and read channels run independent FSMs; responses are always OKAY.
module eth_axi_lite_slave_regs
  import eth_axi_regs_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                        S_AXI_ACLK,
  input  logic                                        S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_AWADDR,
  input  logic [2:0]                                  S_AXI_AWPROT,
  input  logic                                        S_AXI_AWVALID,
  output logic                                        S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             S_AXI_WSTRB,
  input  logic                                        S_AXI_WVALID,
  output logic                                        S_AXI_WREADY,
  output logic [1:0]                                  S_AXI_BRESP,
  output logic                                        S_AXI_BVALID,
  input  logic                                        S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_ARADDR,
  input  logic [2:0]                                  S_AXI_ARPROT,
  input  logic                                        S_AXI_ARVALID,
  output logic                                        S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_RDATA,
  output logic [1:0]                                  S_AXI_RRESP,
  output logic                                        S_AXI_RVALID,
  input  logic                                        S_AXI_RREADY,
  output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                         reg_wr_pulse
);

  // Write channel state
  write_state_t                    w_state_q, w_state_d;
  logic                            awready_q, awready_d;
  logic                            wready_q, wready_d;
  logic                            bvalid_q, bvalid_d;
  logic [IDX_W-1:0]                aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]               wdata_q, wdata_d;
  logic [STRB_W-1:0]               wstrb_q, wstrb_d;
  logic [NUM_REGS-1:0]             wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  // Read channel state
  read_state_t                     r_state_q, r_state_d;
  logic                            arready_q, arready_d;
  logic                            rvalid_q, rvalid_d;
  logic [DATA_W-1:0]               rdata_q, rdata_d;

  logic                            aw_hs_c, w_hs_c, ar_hs_c;
  logic                            commit_c;
  logic [IDX_W-1:0]                c_idx_c;
  logic [DATA_W-1:0]               c_data_c;
  logic [STRB_W-1:0]               c_strb_c;
  logic                            unused_c;

  assign aw_hs_c = S_AXI_AWVALID & awready_q;
  assign w_hs_c  = S_AXI_WVALID  & wready_q;
  assign ar_hs_c = S_AXI_ARVALID & arready_q;

  // Protection bits and byte-offset address bits carry no meaning here.
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM: collect AW and W in either order, commit, then hold B.
  always_comb begin
    w_state_d  = w_state_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    commit_c   = 1'b0;
    c_idx_c    = aw_idx_q;
    c_data_c   = wdata_q;
    c_strb_c   = wstrb_q;

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          commit_c  = 1'b1;
          c_idx_c   = S_AXI_AWADDR[IDX_W+1:2];
          c_data_c  = S_AXI_WDATA;
          c_strb_c  = S_AXI_WSTRB;
          w_state_d = W_RESP;
        end else if (aw_hs_c) begin
          aw_idx_d  = S_AXI_AWADDR[IDX_W+1:2];
          w_state_d = W_HAVE_AW;
        end else if (w_hs_c) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs_c) begin
          commit_c  = 1'b1;
          c_data_c  = S_AXI_WDATA;
          c_strb_c  = S_AXI_WSTRB;
          w_state_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs_c) begin
          commit_c  = 1'b1;
          c_idx_c   = S_AXI_AWADDR[IDX_W+1:2];
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid_q && S_AXI_BREADY) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    // The pulse fires even for an all-zero strobe.
    if (commit_c) begin
      regs_d[c_idx_c]     = strb_merge(regs_q[c_idx_c], c_data_c, c_strb_c);
      wr_pulse_d[c_idx_c] = 1'b1;
    end

    // Readies are derived from the next state so they are registered.
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read FSM: capture the pre-write register value on AR, hold until R.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;

    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          rdata_d   = regs_q[S_AXI_ARADDR[IDX_W+1:2]];
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rvalid_q && S_AXI_RREADY) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
  end

  // State registers for both channels.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      regs_q     <= '0;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign reg_out       = regs_q;
  assign reg_wr_pulse  = wr_pulse_q;

endmodule

// File: tb/tb_eth_axi_lite_slave_regs.sv
// tb_eth_axi_lite_slave_regs
// Directed bench for the register bank. Stimulus pushes expected B responses,
// R data and write pulses into queues; independent monitors pop and compare
// whenever the DUT presents the corresponding output.
module tb_eth_axi_lite_slave_regs;
  import eth_axi_regs_pkg::*;

  logic                            clk;
  logic                            rst;
  logic [3:0]                      awaddr;
  logic [2:0]                      awprot;
  logic                            awvalid;
  logic                            awready;
  logic [31:0]                     wdata;
  logic [3:0]                      wstrb;
  logic                            wvalid;
  logic                            wready;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [3:0]                      araddr;
  logic [2:0]                      arprot;
  logic                            arvalid;
  logic                            arready;
  logic [31:0]                     rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;
  logic [NUM_REGS-1:0][31:0]       reg_out;
  logic [NUM_REGS-1:0]             reg_wr_pulse;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]          bq[$];
  logic [31:0]         rq[$];
  logic [NUM_REGS-1:0] pq[$];

  eth_axi_lite_slave_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no handshake, required one within the cycle budget", nm);
  endtask

  // Monitors: compare whenever a response or pulse is presented.
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (bq.size() == 0) timeout("b_unexpected");
      else check("bresp", 32'(bresp), 32'(bq.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (rq.size() == 0) timeout("r_unexpected");
      else begin
        check("rdata", rdata, rq.pop_front());
        check("rresp", 32'(rresp), 32'(RESP_OKAY));
      end
    end
  end

  always @(negedge clk) begin
    if (reg_wr_pulse != '0) begin
      if (pq.size() == 0) check("wr_pulse_unexpected", 32'(reg_wr_pulse), 32'h0);
      else check("wr_pulse", 32'(reg_wr_pulse), 32'(pq.pop_front()));
    end
  end

  // Channel drivers: called at posedge+1, return at posedge+1 after the handshake.
  task automatic send_aw(input logic [3:0] a);
    bit done = 0;
    awaddr = a; awvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (awready) begin @(posedge clk); #1; done = 1; end
    end
    if (!done) timeout("aw");
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit done = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (wready) begin @(posedge clk); #1; done = 1; end
    end
    if (!done) timeout("w");
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] a);
    bit done = 0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (arready) begin @(posedge clk); #1; done = 1; end
    end
    if (!done) timeout("ar");
    arvalid = 1'b0;
  endtask

  task automatic wait_b();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bvalid && bready) begin @(posedge clk); #1; done = 1; end
    end
    if (!done) timeout("b");
  endtask

  task automatic wait_r();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rvalid && rready) begin @(posedge clk); #1; done = 1; end
    end
    if (!done) timeout("r");
  endtask

  task automatic expect_write(input logic [3:0] a);
    bq.push_back(RESP_OKAY);
    pq.push_back(NUM_REGS'(1) << a[3:2]);
  endtask

  // Issue AW and W with independent lead delays; returns after the later handshake.
  task automatic write_hs(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    fork
      begin
        if (aw_dly > 0) begin
          repeat (aw_dly) @(posedge clk);
          #1;
          check("bvalid_early_aw", 32'(bvalid), 32'h0);
        end
        send_aw(a);
      end
      begin
        if (w_dly > 0) begin
          repeat (w_dly) @(posedge clk);
          #1;
          check("bvalid_early_w", 32'(bvalid), 32'h0);
        end
        send_w(d, s);
      end
    join
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    expect_write(a);
    write_hs(a, d, s, aw_dly, w_dly);
    check("bvalid_latency", 32'(bvalid), 32'h1);
    wait_b();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
    rq.push_back(exp);
    send_ar(a);
    check("rvalid_latency", 32'(rvalid), 32'h1);
    wait_r();
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

    // Reset held 20 cycles.
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'h0);
    check("rst_wready", 32'(wready), 32'h0);
    check("rst_arready", 32'(arready), 32'h0);
    check("rst_bvalid", 32'(bvalid), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_awready_low", 32'(awready), 32'h0);
    @(posedge clk); #1;
    check("rel_readies", 32'({awready, wready, arready}), 32'h7);
    for (int i = 0; i < int'(NUM_REGS); i++) check("rst_reg_out", reg_out[i], 32'h0);
    do_read(REG_CTRL, 32'h0);
    do_read(REG_1, 32'h0);
    do_read(REG_2, 32'h0);
    do_read(REG_3, 32'h0);

    // Basic writes and read-back.
    do_write(REG_CTRL, 32'h1, 4'hF, 0, 0);
    do_write(REG_1, 32'h2, 4'hF, 0, 0);
    do_write(REG_2, 32'h3, 4'hF, 0, 0);
    do_write(REG_3, 32'h4, 4'hF, 0, 0);
    for (int i = 0; i < int'(NUM_REGS); i++) check("reg_out", reg_out[i], 32'(i + 1));
    do_read(REG_CTRL, 32'h1);
    do_read(REG_1, 32'h2);
    do_read(REG_2, 32'h3);
    do_read(REG_3, 32'h4);

    // Partial strobe, zero strobe, and read/write collision on one register.
    do_write(REG_1, 32'hAABBCCDD, 4'b0101, 0, 0);
    do_read(REG_1, 32'h00BB00DD);
    do_write(REG_2, 32'hFFFFFFFF, 4'b0000, 0, 0);
    do_read(REG_2, 32'h3);
    fork
      do_write(REG_1, 32'h0F0F0F0F, 4'hF, 0, 0);
      do_read(REG_1, 32'h00BB00DD);
    join
    do_read(REG_1, 32'h0F0F0F0F);

    // W three cycles before AW, then AW three cycles before W.
    do_write(REG_2, 32'h11223344, 4'hF, 3, 0);
    do_write(REG_3, 32'h55667788, 4'hF, 0, 3);
    do_read(REG_2, 32'h11223344);
    do_read(REG_3, 32'h55667788);

    // B back-pressure: second write waits behind the held response.
    bready = 1'b0;
    expect_write(REG_CTRL);
    write_hs(REG_CTRL, 32'hCAFEF00D, 4'hF, 0, 0);
    check("bvalid_latency_hold", 32'(bvalid), 32'h1);
    expect_write(REG_1);
    fork
      send_aw(REG_1);
      send_w(32'h0BADBEEF, 4'hF);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("hold_bvalid", 32'(bvalid), 32'h1);
          check("hold_readies", 32'({awready, wready}), 32'h0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
      end
    join
    check("bvalid_latency_2nd", 32'(bvalid), 32'h1);
    wait_b();
    do_read(REG_CTRL, 32'hCAFEF00D);
    do_read(REG_1, 32'h0BADBEEF);

    // R back-pressure: RDATA stays put even while the register is rewritten.
    rready = 1'b0;
    rq.push_back(32'hCAFEF00D);
    send_ar(REG_CTRL);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("hold_rvalid", 32'(rvalid), 32'h1);
          check("hold_rdata", rdata, 32'hCAFEF00D);
        end
      end
      do_write(REG_CTRL, 32'h12345678, 4'hF, 0, 0);
    join
    @(posedge clk); #1;
    rready = 1'b1;
    wait_r();
    do_read(REG_CTRL, 32'h12345678);

    // Reset between AW and W aborts the write.
    send_aw(REG_2);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_bvalid", 32'(bvalid), 32'h0);
    end
    @(posedge clk); #1;
    check("abort_reg_out", reg_out[2], 32'h0);
    do_read(REG_2, 32'h0);

    repeat (3) @(posedge clk);
    check("bq_drained", 32'(bq.size()), 32'h0);
    check("rq_drained", 32'(rq.size()), 32'h0);
    check("pq_drained", 32'(pq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
